// File: rtl/dnn_mem_loader_fix.sv
// Streams words from a valid/ready source into one of four memory regions.
// Optional checksum trailer check is compiled in with DNN_LOADER_CHECKSUM_EN.
module dnn_mem_loader_fix #(
  parameter int DATA_WIDTH = 13,
  parameter int ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_A = 16'h0000,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_W = 16'h0191,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_LUT_L1 = 16'h29be,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_LUT_L2 = 16'h49be,
  parameter int LEN_A = 401,
  parameter int LEN_W = 10285,
  parameter int LEN_LUT_L1 = 8192,
  parameter int LEN_LUT_L2 = 8192
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         reset,
  input  logic                         cmd_valid,
  input  logic [1:0]                   cmd_region,
  input  logic                         cmd_autostart,
  output logic                         cmd_ready,
  input  logic                         s_valid,
  input  logic signed [DATA_WIDTH-1:0] s_data,
  output logic                         s_ready,
  output logic                         mem_we,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic signed [DATA_WIDTH-1:0] mem_wdata,
  output logic                         eng_start,
  input  logic                         eng_done,
  output logic                         load_done,
  output logic                         busy,
  output logic                         err
);

`ifdef DNN_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, LOAD, CHECK, FIN, RUN
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, LOAD, FIN, RUN
  } state_t;
`endif

  state_t state, state_n;

  logic [1:0]            region_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] base_sel;
  logic [31:0]           len_q;
  logic [31:0]           len_sel;
  logic [31:0]           count;
  logic                  auto_q;
  logic                  armed;
  logic                  cmd_fire;
  logic                  xfer;
  logic                  last;
  logic                  in_load;

`ifdef DNN_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum;
  logic                  in_check;
  assign in_check = (state == CHECK);
`endif

  always_comb begin
    base_sel = ADDR_BASE_A;
    len_sel  = 32'(LEN_A);
    unique case (cmd_region)
      2'd0: begin
        base_sel = ADDR_BASE_A;
        len_sel  = 32'(LEN_A);
      end
      2'd1: begin
        base_sel = ADDR_BASE_W;
        len_sel  = 32'(LEN_W);
      end
      2'd2: begin
        base_sel = ADDR_BASE_LUT_L1;
        len_sel  = 32'(LEN_LUT_L1);
      end
      default: begin
        base_sel = ADDR_BASE_LUT_L2;
        len_sel  = 32'(LEN_LUT_L2);
      end
    endcase
  end

  // cmd_ready stays low until the first clock after async reset
  assign cmd_ready = armed && (state == IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready && !reset;
  assign in_load   = (state == LOAD);
`ifdef DNN_LOADER_CHECKSUM_EN
  assign s_ready = !reset && (in_load || in_check);
`else
  assign s_ready = !reset && in_load;
`endif
  assign xfer      = s_valid && s_ready;
  assign last      = (count == len_q - 32'd1);
  assign load_done = !reset && (state == FIN);
  assign eng_start = load_done && (region_q == 2'd0)
                     && auto_q && !err;
  assign busy      = (state != IDLE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (cmd_fire) state_n = LOAD;
      LOAD: begin
        if (xfer && last) begin
`ifdef DNN_LOADER_CHECKSUM_EN
          state_n = CHECK;
`else
          state_n = FIN;
`endif
        end
      end
`ifdef DNN_LOADER_CHECKSUM_EN
      CHECK: if (xfer) state_n = FIN;
`endif
      FIN: state_n = eng_start ? RUN : IDLE;
      RUN: if (eng_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (reset) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      armed     <= 1'b0;
      region_q  <= 2'd0;
      base_q    <= '0;
      len_q     <= '0;
      auto_q    <= 1'b0;
      count     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state  <= state_n;
      armed  <= 1'b1;
      mem_we <= 1'b0;
      if (reset) begin
        count <= '0;
      end else begin
        if (cmd_fire) begin
          region_q <= cmd_region;
          base_q   <= base_sel;
          len_q    <= len_sel;
          auto_q   <= cmd_autostart;
          count    <= '0;
        end
        if (xfer && in_load) begin
          mem_we    <= 1'b1;
          mem_addr  <= base_q + count[ADDR_WIDTH-1:0];
          mem_wdata <= s_data;
          count     <= count + 32'd1;
        end
      end
    end
  end

`ifdef DNN_LOADER_CHECKSUM_EN
  // trailer word is compared against the wrapped sum, never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
      err <= 1'b0;
    end else if (reset) begin
      sum <= '0;
      err <= 1'b0;
    end else begin
      if (cmd_fire) sum <= '0;
      if (xfer && in_load) sum <= sum + s_data;
      if (xfer && in_check && (s_data != sum)) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dnn_mem_loader_fix.sv
// Scoreboard bench for dnn_mem_loader_fix; expected writes are queued
// as words are offered and retired by the write-port monitor.
module tb_dnn_mem_loader_fix;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic reset = 1'b0;
  logic cmd_valid = 1'b0;
  logic [1:0] cmd_region = 2'd0;
  logic cmd_autostart = 1'b0;
  logic cmd_ready;
  logic s_valid = 1'b0;
  logic signed [12:0] s_data = '0;
  logic s_ready;
  logic mem_we;
  logic [15:0] mem_addr;
  logic signed [12:0] mem_wdata;
  logic eng_start;
  logic eng_done = 1'b0;
  logic load_done;
  logic busy;
  logic err;

  int errors = 0;
  int checks = 0;
  int nwrites = 0;
  logic [15:0] last_addr = '0;
  logic [28:0] sb[$];

  always #5 clk = ~clk;

  dnn_mem_loader_fix dut (
    .clk(clk), .rst(rst), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_region(cmd_region),
    .cmd_autostart(cmd_autostart), .cmd_ready(cmd_ready),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .eng_start(eng_start), .eng_done(eng_done),
    .load_done(load_done), .busy(busy), .err(err)
  );

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      logic [28:0] e;
      nwrites++;
      last_addr = mem_addr;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%0d", mem_addr, mem_wdata);
      end else begin
        e = sb.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          errors++;
          $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                   mem_addr, mem_wdata, e[28:13], e[12:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [1:0] r, input logic a);
    cmd_valid = 1'b1;
    cmd_region = r;
    cmd_autostart = a;
    step();
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept busy=%b want 1", busy);
    end
  endtask

  task automatic stream(input logic [15:0] base, input int n,
                        input int inc, input int off, input bit thr,
                        output logic [12:0] sum);
    int i = 0;
    int cyc = 0;
    bit x;
    logic [12:0] d;
    sum = '0;
    while (i < n) begin
      d = 13'(i * inc + off);
      s_data = d;
      s_valid = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      x = s_valid && s_ready;
      if (x) sb.push_back({16'(base + 16'(i)), d});
      step();
      if (x) begin
        i++;
        sum = sum + d;
      end
      cyc++;
      if (cyc > n * 8 + 100) begin
        errors++;
        checks++;
        $display("FAIL stream_timeout sent=%0d want %0d", i, n);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic finish_load(input logic [12:0] sum);
`ifdef DNN_LOADER_CHECKSUM_EN
    s_valid = 1'b1;
    s_data = sum;
    step();
    s_valid = 1'b0;
`else
    checks++;
    if (load_done !== 1'b1 || sum !== sum) begin
      errors++;
      $display("FAIL load_done_direct got %b want 1", load_done);
    end
`endif
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({cmd_ready, s_ready, mem_we, mem_addr, mem_wdata,
         eng_start, load_done, busy, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0",
               {cmd_ready, s_ready, mem_we, mem_addr, mem_wdata,
                eng_start, load_done, busy, err});
    end
    step();
    rst = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_cmd_ready got %b want 0", cmd_ready);
    end
    step();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_after_reset got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_region_a();
    logic [12:0] s;
    issue_cmd(2'd0, 1'b1);
    stream(16'h0000, 401, 1, 0, 1'b0, s);
    finish_load(s);
    checks++;
    if (load_done !== 1'b1 || eng_start !== 1'b1) begin
      errors++;
      $display("FAIL a_fin load_done=%b eng_start=%b want 1 1",
               load_done, eng_start);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL a_err got %b want 0", err);
    end
    step();
    checks++;
    if (busy !== 1'b1 || load_done !== 1'b0 || eng_start !== 1'b0) begin
      errors++;
      $display("FAIL a_run busy=%b ld=%b es=%b want 1 0 0",
               busy, load_done, eng_start);
    end
  endtask

  task automatic test_run_ignore();
    cmd_valid = 1'b1;
    s_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (cmd_ready !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL run_ignore cr=%b sr=%b busy=%b want 0 0 1",
                 cmd_ready, s_ready, busy);
      end
      step();
    end
    cmd_valid = 1'b0;
    s_valid = 1'b0;
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL run_done busy=%b cr=%b want 0 1", busy, cmd_ready);
    end
  endtask

  task automatic test_region_w_throttled();
    logic [12:0] s;
    int w0;
    w0 = nwrites;
    issue_cmd(2'd1, 1'b1);
    stream(16'h0191, 10285, 3, 5, 1'b1, s);
    finish_load(s);
    checks++;
    if (load_done !== 1'b1 || eng_start !== 1'b0) begin
      errors++;
      $display("FAIL w_fin ld=%b es=%b want 1 0", load_done, eng_start);
    end
    @(negedge clk);
    #1;
    checks++;
    if (nwrites - w0 !== 10285 || last_addr !== 16'h29bd) begin
      errors++;
      $display("FAIL w_count n=%0d last=%h want 10285 29bd",
               nwrites - w0, last_addr);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL w_idle busy=%b want 0", busy);
    end
  endtask

  task automatic test_lut_l2();
    logic [12:0] s;
    issue_cmd(2'd3, 1'b1);
    stream(16'h49be, 8192, 1, 7, 1'b0, s);
    finish_load(s);
    checks++;
    if (load_done !== 1'b1 || eng_start !== 1'b0) begin
      errors++;
      $display("FAIL l2_fin ld=%b es=%b want 1 0", load_done, eng_start);
    end
    @(negedge clk);
    #1;
    checks++;
    if (last_addr !== 16'h69bd) begin
      errors++;
      $display("FAIL l2_last got %h want 69bd", last_addr);
    end
    step();
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL l2_idle busy=%b cr=%b ld=%b want 0 1 0",
               busy, cmd_ready, load_done);
    end
  endtask

  task automatic test_idle_ignore();
    s_valid = 1'b1;
    eng_done = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (s_ready !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_ignore sr=%b busy=%b cr=%b want 0 0 1",
                 s_ready, busy, cmd_ready);
      end
      step();
    end
    s_valid = 1'b0;
    eng_done = 1'b0;
  endtask

  task automatic test_rst_mid_load();
    logic [12:0] s;
    issue_cmd(2'd1, 1'b0);
    stream(16'h0191, 100, 1, 0, 1'b0, s);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({cmd_ready, s_ready, mem_we, mem_addr, mem_wdata,
         eng_start, load_done, busy, err} !== '0) begin
      errors++;
      $display("FAIL rst_mid_load got %b want 0",
               {cmd_ready, s_ready, mem_we, mem_addr, mem_wdata,
                eng_start, load_done, busy, err});
    end
    #1 rst = 1'b0;
    step();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_recover cr=%b want 1", cmd_ready);
    end
    issue_cmd(2'd1, 1'b0);
    stream(16'h0191, 3, 1, 100, 1'b0, s);
  endtask

  task automatic test_soft_reset();
    s_valid = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL soft_reset_sready got %b want 0", s_ready);
    end
    step();
    reset = 1'b0;
    s_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || err !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL soft_reset busy=%b err=%b cr=%b want 0 0 1",
               busy, err, cmd_ready);
    end
  endtask

`ifdef DNN_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [12:0] s;
    issue_cmd(2'd0, 1'b1);
    stream(16'h0000, 401, 0, 1, 1'b0, s);
    finish_load(13'd401);
    checks++;
    if (load_done !== 1'b1 || err !== 1'b0 || eng_start !== 1'b1) begin
      errors++;
      $display("FAIL csum_ok ld=%b err=%b es=%b want 1 0 1",
               load_done, err, eng_start);
    end
    step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    issue_cmd(2'd0, 1'b1);
    stream(16'h0000, 401, 0, 1, 1'b0, s);
    finish_load(13'd0);
    checks++;
    if (load_done !== 1'b1 || err !== 1'b1 || eng_start !== 1'b0) begin
      errors++;
      $display("FAIL csum_bad ld=%b err=%b es=%b want 1 1 0",
               load_done, err, eng_start);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL csum_idle busy=%b want 0", busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_region_a();
    test_run_ignore();
    test_idle_ignore();
    test_region_w_throttled();
    test_lut_l2();
    test_rst_mid_load();
    test_soft_reset();
`ifdef DNN_LOADER_CHECKSUM_EN
    test_checksum();
    test_soft_reset();
`endif
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dnn_mem_loader_fix.md
DNN_MEM_LOADER_FIX -- requirements
Module: dnn_mem_loader_fix

Interface
REQ-001 Parameter DATA_WIDTH, default 13, word width of stream and memory data.
REQ-002 Parameter ADDR_WIDTH, default 16, memory address width.
REQ-003 Parameters ADDR_BASE_A/W/LUT_L1/LUT_L2, defaults 16'h0000/16'h0191/16'h29be/16'h49be, region base addresses.
REQ-004 Parameters LEN_A/W/LUT_L1/LUT_L2, defaults 401/10285/8192/8192, region word counts.
REQ-005 clk input 1: single clock; all state on rising edge.
REQ-006 rst input 1: asynchronous, active-high reset.
REQ-007 reset input 1: synchronous soft clear, active-high.
REQ-008 cmd_valid input 1: load command request; cmd_region input 2: 0=A, 1=W, 2=LUT_L1, 3=LUT_L2; cmd_autostart input 1: pulse engine start after region A load.
REQ-009 cmd_ready output 1: high only in IDLE.
REQ-010 s_valid input 1, s_data input signed DATA_WIDTH, s_ready output 1: word stream, transfer when s_valid&&s_ready.
REQ-011 mem_we output 1, mem_addr output ADDR_WIDTH, mem_wdata output signed DATA_WIDTH: memory write port.
REQ-012 eng_start output 1 (pulse), eng_done input 1: inference-engine start/done handshake.
REQ-013 load_done output 1 (one-cycle pulse); busy output 1; err output 1 (sticky).

Function
REQ-014 States IDLE, LOAD, CHECK, FIN, RUN; transitions only as below.
REQ-015 IDLE: cmd_valid&&cmd_ready latches region, base, length, autostart; word counter=0; next LOAD.
REQ-016 LOAD: s_ready=1; each transfer drives mem_we=1, mem_addr=base+count, mem_wdata=s_data registered, one-cycle write latency from transfer.
REQ-017 count increments per transfer; transfer with count==length-1 moves to CHECK (macro on) or FIN (macro off).
REQ-018 s_valid low in LOAD: no write, counter holds; no timeout.
REQ-019 Address arithmetic modulo 2^ADDR_WIDTH; no bounds check beyond length.
REQ-020 FIN: load_done=1 for exactly one cycle; if latched region==A and autostart==1, eng_start=1 same cycle and next RUN, else next IDLE.
REQ-021 RUN: cmd_ready=0, s_ready=0; eng_done high -> IDLE; eng_done in any other state ignored.
REQ-022 busy=1 in every state except IDLE.
REQ-023 cmd_valid outside IDLE ignored, not queued.
REQ-024 s_valid outside LOAD not accepted (s_ready=0), no write.
REQ-025 Soft reset has priority over all transitions: next state IDLE, counter 0, err 0, pulses suppressed that cycle.

Reset
REQ-026 rst high asynchronously forces IDLE, count=0, mem_we=0, mem_addr=0, mem_wdata=0, eng_start=0, load_done=0, err=0, busy=0, s_ready=0; cmd_ready=1 after first edge with rst low.
REQ-027 rst mid-LOAD discards partial load; no further writes issued.

Configuration
REQ-028 Macro DNN_LOADER_CHECKSUM_EN compiled in: running sum of loaded words, DATA_WIDTH-bit wrap-around; CHECK accepts one extra stream word (no memory write), sets err=1 if unequal to sum, then FIN.
REQ-029 Without DNN_LOADER_CHECKSUM_EN: no CHECK state, no sum logic, err tied 0, LOAD goes directly to FIN.
REQ-030 With macro, err=1 blocks eng_start; FIN returns to IDLE.

Verification
REQ-031 Region A, autostart=1, 401 words 0..400 at full rate -> writes addr 0x0000..0x0190 data 0..400, load_done and eng_start pulse together, busy until eng_done.
REQ-032 Region W, s_valid toggled 50% -> 10285 writes starting 0x0191, final addr 0x29bd, no duplicate or skipped address.
REQ-033 Region LUT_L2, 8192 words -> last write addr 0x69bd, load_done pulse, no eng_start, return IDLE.
REQ-034 rst asserted after 100 words of region W -> all outputs zero immediately, next command restarts at 0x0191.
REQ-035 Macro on, region A words all 1, checksum word 401 mod 8192 -> err=0, eng_start; checksum 0 -> err=1, no eng_start.
REQ-036 cmd_valid during RUN and s_valid during IDLE -> ignored, no writes, state unchanged.
